charlie_keyscan: RTL and testbench
==================================

# charlie_keyscan

Scans a 6-pin charlieplexed key matrix (30 keys) using the same row/column pin mapping as the LED display driver, debounces the matrix and emits one key event at a time over a valid/ready interface. It sits beside the display block on the front-panel pins and feeds the time-setting logic that drives the clock counters. The display writes the panel; this block reads it.

## Interface
- DWELL, 8, clk cycles each row is driven; minimum 4.
- DEBOUNCE, 2, consecutive identical frames before the debounced state updates; minimum 1.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high; clock clk
- pins_in  in  6  raw panel pin levels; external pull-downs, asynchronous
- pins_oe  out  6  pin output enable, one-hot during scan
- pins_out  out  6  pin drive value, equal to pins_oe
- key_valid  out  1  event available
- key_ready  in  1  consumer accepts event
- key_code  out  5  key index = row*5 + col, 0..29
- key_pressed  out  1  1 = press, 0 = release

## Operation
- Row counter r cycles 0..5, wraps 5→0. Dwell counter d cycles 0..DWELL-1 and advances r on d = DWELL-1.
- Drive: pins_oe = pins_out = 1<<r, registered. All other pins are inputs.
- pins_in passes through a 2-flop synchroniser. At d = DWELL-1, the synchronised pins are sampled into frame row r. Bit r is dropped. Pin p maps to column c = p for p<r, and c = p-1 for p>r.
- Frame end is the sample at r=5. The completed frame (30 bits) is compared with the previous frame:
  - Equal: stable_cnt increments, saturating at DEBOUNCE.
  - Different: stable_cnt is cleared.
  - When the post-update stable_cnt equals DEBOUNCE, debounced <= frame. The compared frame then becomes the previous frame.
- Event selection:
  - pending = debounced XOR reported.
  - The output register is free when key_valid=0, or when key_valid & key_ready.
  - When the output register is free and pending≠0, load the lowest set index i: key_code=i, key_pressed=debounced[i], reported[i] <= debounced[i].
- A key that bounces back before it is reported clears its pending bit with no event.
- Scanning never stalls. A consumer back-pressure of any length loses no final state, but intermediate toggles collapse.

## Timing
- Reset values:
  - pins_oe=0, pins_out=0, key_valid=0, key_code=0, key_pressed=0.
  - r=0, d=0, stable_cnt=0.
  - frame, previous, debounced and reported are all 0.
- The first clk edge after rst deasserts drives row 0. Row r is driven for exactly DWELL cycles. A frame takes 6*DWELL cycles.
- A press stable from the start of frame k updates debounced at the end of frame k+DEBOUNCE. key_valid rises 1 cycle later, provided the output register is free.
- key_valid, key_code and key_pressed hold stable while key_valid & !key_ready.
- Back-to-back throughput: one event per cycle while key_ready=1.
- Simultaneous debounced update and handshake in the same cycle: selection uses the pending value computed from the pre-update debounced.
- rst asserted mid-scan or mid-handshake clears all state immediately. Any event in flight is discarded.

## Configuration
- KEYSCAN_RELEASE_EN defined:
  - pending = debounced XOR reported.
  - Both presses and releases emit events.
- Undefined:
  - pending = debounced & ~reported.
  - Releases clear reported bits silently and emit no event.
  - key_pressed is constant 1.

## Structure
- Shared package charlie_pkg holds:
  - NUM_PINS=6 and NUM_KEYS=30.
  - key_code_t (5-bit).
  - The pin→column mapping function, shared with the display driver so both ends agree on geometry.
- Sub-module charlie_debounce holds the frame compare, stable_cnt and debounced register: input is the frame plus a frame_done strobe, output is debounced.
- The top level holds the scan counters, pin drive, synchroniser and event emitter.

## Test plan
All scenarios use DWELL=8 and DEBOUNCE=2, so a frame is 48 cycles.
- Reset: hold rst for 5 cycles → all outputs 0. The first cycle after release gives pins_oe=6'b000001. pins_oe rotates to 6'b000010 after 8 cycles.
- Press mapping:
  - pins_in[3]=1 only while r=0 → one event with key_code=2, key_pressed=1.
  - pins_in[1]=1 only while r=4 → key_code=21.
- Bounce: toggle key 7 in alternate frames for 6 frames, then hold it → exactly one press event, emitted 2 frames after the hold starts plus 1 cycle.
- Back-pressure: press keys 0, 5 and 29 in the same frame with key_ready=0 → key_valid holds key_code=0. Raising key_ready gives key_code 0, 5, 29 on consecutive cycles.
- Release: release key 5 after reporting it → with KEYSCAN_RELEASE_EN, key_code=5 and key_pressed=0. Without it, no event.
- Mid-operation reset: pulse rst while key_valid=1 and pending≠0 → key_valid=0 immediately. A still-held key re-reports as a press after 3 frames.

Source files
------------

// File: rtl/charlie_pkg.sv
// charlie_pkg: shared geometry for the 6-pin charlieplexed front panel.
//
// Both the LED display driver and the key scanner import this package so
// that a (row, pin) pair always resolves to the same key/LED index.
//
// Contents:
//   NUM_PINS, NUM_COLS, NUM_KEYS   panel geometry (6 pins, 5 columns, 30 keys)
//   key_code_t                     5-bit key index, row*5 + col
//   key_vec_t                      one bit per key
//   pin_idx_t                      3-bit pin / row number
//   pin_to_col()                   pin -> column for a given driven row
//   key_index()                    (row, col) -> key index
//   lowest_set()                   index of the lowest set bit of a key vector
package charlie_pkg;

    localparam int unsigned NUM_PINS = 6;
    localparam int unsigned NUM_COLS = NUM_PINS - 1;
    localparam int unsigned NUM_KEYS = NUM_PINS * NUM_COLS;

    typedef logic [4:0]          key_code_t;
    typedef logic [NUM_KEYS-1:0] key_vec_t;
    typedef logic [2:0]          pin_idx_t;

    // The driven row's own pin carries no key, so the pins above it shift
    // down by one column to keep the column range dense (0..4).
    function automatic pin_idx_t pin_to_col(input pin_idx_t row, input pin_idx_t pin);
        return (pin < row) ? pin : pin - 3'd1;
    endfunction

    function automatic key_code_t key_index(input pin_idx_t row, input pin_idx_t col);
        return key_code_t'(NUM_COLS * row + col);
    endfunction

    // Returns 0 when no bit is set; callers qualify with a non-zero test.
    function automatic key_code_t lowest_set(input key_vec_t v);
        key_code_t idx   = '0;
        logic      found = 1'b0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (v[i] && !found) begin
                idx   = key_code_t'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/charlie_debounce.sv
// charlie_debounce: frame-level debouncer for the charlieplexed key matrix.
//
// Each completed scan frame is compared with the previous one. A frame
// must repeat DEBOUNCE times in a row before it is copied into the
// debounced state.
//
// Parameters:
//   DEBOUNCE    consecutive identical frames required (minimum 1)
// Ports:
//   clk         clock
//   rst         asynchronous active-high reset
//   frame       completed frame, valid while frame_done is high
//   frame_done  one-cycle strobe marking the end of a frame
//   debounced   debounced key state, one bit per key
module charlie_debounce
    import charlie_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  key_vec_t frame,
    input  logic     frame_done,
    output key_vec_t debounced
);

    localparam int unsigned     CW      = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE);

    key_vec_t        previous;
    logic [CW-1:0]   stable_cnt;
    logic [CW-1:0]   cnt_next;

    always_comb begin
        cnt_next = '0;
        if (frame == previous) begin
            cnt_next = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            previous   <= '0;
            stable_cnt <= '0;
            debounced  <= '0;
        end else if (frame_done) begin
            stable_cnt <= cnt_next;
            previous   <= frame;
            // Decision uses the post-update count so the frame that reaches
            // DEBOUNCE repeats is the one that gets committed.
            if (cnt_next == CNT_MAX) begin
                debounced <= frame;
            end
        end
    end

endmodule

// File: rtl/charlie_keyscan.sv
// charlie_keyscan: charlieplexed 30-key front-panel scanner.
//
// Drives one panel pin high per row (one-hot), samples the remaining five
// pins through a 2-flop synchroniser, assembles a 30-bit frame, debounces
// it and reports key changes one at a time over a valid/ready interface.
//
// Build option:
//   KEYSCAN_RELEASE_EN  when defined, releases are reported as events with
//                       key_pressed=0; otherwise only presses are reported
//                       and releases are absorbed silently.
//
// Parameters:
//   DWELL        clk cycles each row is driven (minimum 4)
//   DEBOUNCE     consecutive identical frames before update (minimum 1)
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset
//   pins_in      raw panel pin levels (asynchronous, pulled down)
//   pins_oe      pin output enable, one-hot during scan
//   pins_out     pin drive value, equal to pins_oe
//   key_valid    event available
//   key_ready    consumer accepts event
//   key_code     key index = row*5 + col
//   key_pressed  1 = press, 0 = release
module charlie_keyscan
    import charlie_pkg::*;
#(
    parameter int unsigned DWELL    = 8,
    parameter int unsigned DEBOUNCE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] pins_in,
    output logic [5:0] pins_oe,
    output logic [5:0] pins_out,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [4:0] key_code,
    output logic       key_pressed
);

    localparam int unsigned           DW       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]         D_LAST   = DW'(DWELL - 1);
    localparam pin_idx_t              LAST_ROW = pin_idx_t'(NUM_PINS - 1);
    localparam logic [NUM_PINS-1:0]   ROW0_OE  = {{(NUM_PINS-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Scan counters and pin drive
    // ------------------------------------------------------------------
    pin_idx_t       row;
    logic [DW-1:0]  dwell;
    logic           sample;
    logic           frame_done;

    assign sample     = (dwell == D_LAST);
    assign frame_done = sample && (row == LAST_ROW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row     <= '0;
            dwell   <= '0;
            pins_oe <= '0;
        end else begin
            // Drive follows the counter by one cycle, so each row is on the
            // pins for exactly DWELL cycles and is settled well before its
            // sample point at the end of the dwell.
            pins_oe <= ROW0_OE << row;
            if (sample) begin
                dwell <= '0;
                row   <= (row == LAST_ROW) ? '0 : row + 3'd1;
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

    assign pins_out = pins_oe;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic [NUM_PINS-1:0] pins_meta;
    logic [NUM_PINS-1:0] pins_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pins_meta <= '0;
            pins_sync <= '0;
        end else begin
            pins_meta <= pins_in;
            pins_sync <= pins_meta;
        end
    end

    // ------------------------------------------------------------------
    // Frame assembly
    // ------------------------------------------------------------------
    key_vec_t frame;
    key_vec_t frame_next;

    always_comb begin
        frame_next = frame;
        if (sample) begin
            for (int unsigned p = 0; p < NUM_PINS; p++) begin
                if (pin_idx_t'(p) != row) begin
                    frame_next[key_index(row, pin_to_col(row, pin_idx_t'(p)))] = pins_sync[p];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame <= '0;
        end else begin
            frame <= frame_next;
        end
    end

    // ------------------------------------------------------------------
    // Debouncer: fed the combinational frame so the last row's sample is
    // included in the same cycle as frame_done.
    // ------------------------------------------------------------------
    key_vec_t debounced;

    charlie_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .frame      (frame_next),
        .frame_done (frame_done),
        .debounced  (debounced)
    );

    // ------------------------------------------------------------------
    // Event emitter
    // ------------------------------------------------------------------
    key_vec_t  reported;
    key_vec_t  reported_next;
    key_vec_t  pending;
    key_code_t sel;
    logic      out_free;
    logic      load;
    logic      sel_pressed;

    always_comb begin
`ifdef KEYSCAN_RELEASE_EN
        pending       = debounced ^ reported;
        reported_next = reported;
        sel_pressed   = 1'b0;
`else
        pending       = debounced & ~reported;
        // Released keys drop out of reported without producing an event.
        reported_next = reported & debounced;
        sel_pressed   = 1'b1;
`endif
        out_free = !key_valid || key_ready;
        load     = out_free && (pending != '0);
        sel      = lowest_set(pending);
`ifdef KEYSCAN_RELEASE_EN
        sel_pressed = debounced[sel];
`endif
        if (load) begin
            reported_next[sel] = debounced[sel];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reported    <= '0;
            key_valid   <= 1'b0;
            key_code    <= '0;
            key_pressed <= 1'b0;
        end else begin
            reported <= reported_next;
            if (load) begin
                key_valid   <= 1'b1;
                key_code    <= sel;
                key_pressed <= sel_pressed;
            end else if (out_free) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_charlie_keyscan.sv
// tb_charlie_keyscan: directed self-checking bench for charlie_keyscan.
//
// A behavioural panel model turns the bench's key vector into pin levels
// for whichever row is currently driven. Expected values are hand-computed
// for DWELL=8, DEBOUNCE=2 (48-cycle frames). cyc counts clock edges since
// the last reset release, matching the scan position.
module tb_charlie_keyscan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  pins_in;
    logic [5:0]  pins_oe;
    logic [5:0]  pins_out;
    logic        key_valid;
    logic        key_ready;
    logic [4:0]  key_code;
    logic        key_pressed;

    logic [29:0] keys;
    int          checks   = 0;
    int          failures = 0;
    int          cyc;

    always #5 clk = ~clk;

    charlie_keyscan #(
        .DWELL    (8),
        .DEBOUNCE (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pins_in     (pins_in),
        .pins_oe     (pins_oe),
        .pins_out    (pins_out),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_code    (key_code),
        .key_pressed (key_pressed)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Panel model: the driven pin reads high; a pressed key connects the
    // driven row to the pin of its column (column skips the row's own pin).
    always_comb begin
        pins_in = '0;
        for (int r = 0; r < 6; r++) begin
            if (pins_oe == (6'd1 << r)) begin
                for (int p = 0; p < 6; p++) begin
                    if (p == r)     pins_in[p] = 1'b1;
                    else if (p < r) pins_in[p] = keys[r*5 + p];
                    else            pins_in[p] = keys[r*5 + p - 1];
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int target);
        if (cyc > target) begin
            checks++;
            failures++;
            $display("FAIL goto actual=%0d expected<=%0d", cyc, target);
        end
        while (cyc < target) step();
    endtask

    task automatic next_frame();
        step();
        while (cyc % 48 != 0) step();
    endtask

    typedef struct {
        int         c;
        logic [5:0] oe;
    } rot_t;

    typedef struct {
        logic [29:0] keys;
        logic        v1;
        int          c1;
        logic        p1;
        logic        v2;
        int          c2;
        logic        p2;
    } vec_t;

    initial begin
        rot_t rot[8];
        vec_t tbl[5];
        int   base;
        int   ev;
        int   waited;

        rot[0] = '{1,  6'b000001};
        rot[1] = '{8,  6'b000001};
        rot[2] = '{9,  6'b000010};
        rot[3] = '{16, 6'b000010};
        rot[4] = '{17, 6'b000100};
        rot[5] = '{41, 6'b100000};
        rot[6] = '{48, 6'b100000};
        rot[7] = '{49, 6'b000001};

        // Key 2 lives on row 0 / pin 3, key 21 on row 4 / pin 1.
        tbl[0] = '{30'd1 << 2,  1'b1, 2,  1'b1, 1'b0, 0, 1'b0};
`ifdef KEYSCAN_RELEASE_EN
        tbl[1] = '{30'd0,       1'b1, 2,  1'b0, 1'b0, 0, 1'b0};
`else
        tbl[1] = '{30'd0,       1'b0, 0,  1'b0, 1'b0, 0, 1'b0};
`endif
        tbl[2] = '{30'd1 << 21, 1'b1, 21, 1'b1, 1'b0, 0, 1'b0};
`ifdef KEYSCAN_RELEASE_EN
        tbl[3] = '{30'd1 << 5,  1'b1, 5,  1'b1, 1'b1, 21, 1'b0};
        tbl[4] = '{30'd0,       1'b1, 5,  1'b0, 1'b0, 0, 1'b0};
`else
        tbl[3] = '{30'd1 << 5,  1'b1, 5,  1'b1, 1'b0, 0, 1'b0};
        tbl[4] = '{30'd0,       1'b0, 0,  1'b0, 1'b0, 0, 1'b0};
`endif

        keys      = '0;
        key_ready = 1'b1;
        rst       = 1'b1;

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        check("rst_oe",      pins_oe,     0);
        check("rst_out",     pins_out,    0);
        check("rst_valid",   key_valid,   0);
        check("rst_code",    key_code,    0);
        check("rst_pressed", key_pressed, 0);
        rst = 1'b0;
        check("oe_pre_edge", pins_oe, 0);

        // Row rotation
        foreach (rot[i]) begin
            goto(rot[i].c);
            check($sformatf("rot%0d_oe", i), pins_oe, rot[i].oe);
            check($sformatf("rot%0d_out", i), pins_out, rot[i].oe);
        end

        // Press/release vectors: held from a frame start, debounced at the
        // end of the third frame (edge +144), event one cycle later.
        foreach (tbl[i]) begin
            next_frame();
            base = cyc;
            keys = tbl[i].keys;
            goto(base + 144);
            check($sformatf("vec%0d_early", i), key_valid, 0);
            step();
            check($sformatf("vec%0d_valid", i), key_valid, tbl[i].v1);
            if (tbl[i].v1) begin
                check($sformatf("vec%0d_code", i), key_code, tbl[i].c1);
                check($sformatf("vec%0d_pressed", i), key_pressed, tbl[i].p1);
            end
            step();
            check($sformatf("vec%0d_valid2", i), key_valid, tbl[i].v2);
            if (tbl[i].v2) begin
                check($sformatf("vec%0d_code2", i), key_code, tbl[i].c2);
                check($sformatf("vec%0d_pressed2", i), key_pressed, tbl[i].p2);
            end
        end

        // Bounce: key 7 off/on in alternate frames (on in frames 2, 4, 6),
        // then held; one press event 2 frames after the hold starts + 1.
        next_frame();
        ev = 0;
        for (int f = 1; f <= 6; f++) begin
            keys[7] = (f % 2 == 0);
            repeat (48) begin
                step();
                if (key_valid) ev++;
            end
        end
        for (int k = 0; k < 96; k++) begin
            step();
            if (key_valid) ev++;
        end
        check("bounce_early_events", ev, 0);
        step();
        check("bounce_valid",   key_valid,   1);
        check("bounce_code",    key_code,    7);
        check("bounce_pressed", key_pressed, 1);
        ev = 0;
        repeat (100) begin
            step();
            if (key_valid) ev++;
        end
        check("bounce_extra_events", ev, 0);

        keys = '0;
        repeat (4 * 48) step();

        // Back-pressure: three presses in one frame with key_ready low
        next_frame();
        base      = cyc;
        key_ready = 1'b0;
        keys      = (30'd1 << 0) | (30'd1 << 5) | (30'd1 << 29);
        goto(base + 145);
        check("bp_valid",   key_valid,   1);
        check("bp_code",    key_code,    0);
        check("bp_pressed", key_pressed, 1);
        repeat (20) step();
        check("bp_hold_valid", key_valid, 1);
        check("bp_hold_code",  key_code,  0);
        key_ready = 1'b1;
        step();
        check("bp_second_valid", key_valid, 1);
        check("bp_second_code",  key_code,  5);
        step();
        check("bp_third_valid", key_valid, 1);
        check("bp_third_code",  key_code,  29);
        step();
        check("bp_drained", key_valid, 0);

        // Mid-handshake reset with more events pending
        key_ready = 1'b0;
        next_frame();
        keys   = (30'd1 << 3) | (30'd1 << 9);
        waited = 0;
        while (!key_valid && waited < 400) begin
            step();
            waited++;
        end
        check("midrst_event_seen", key_valid, 1);
        rst = 1'b1;
        #1;
        check("midrst_valid", key_valid, 0);
        check("midrst_code",  key_code,  0);
        check("midrst_oe",    pins_oe,   0);
        step();
        rst       = 1'b0;
        key_ready = 1'b1;
        goto(144);
        check("rerep_early", key_valid, 0);
        step();
        check("rerep_valid",   key_valid,   1);
        check("rerep_code",    key_code,    3);
        check("rerep_pressed", key_pressed, 1);
        step();
        check("rerep2_valid",   key_valid,   1);
        check("rerep2_code",    key_code,    9);
        check("rerep2_pressed", key_pressed, 1);
        step();
        check("rerep_drained", key_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
